// File: rtl/main_mem_ctrl.sv
// Latency-modelled, byte-addressable block memory behind a valid/ready request/response handshake.
// Serves whole-block reads and byte-masked block writes, and flags out-of-range accesses.
module main_mem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BLK_WIDTH = 64,
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned INIT      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [PA_WIDTH-1:0]           req_addr,
  input  logic [BLK_WIDTH-1:0]          req_wdata,
  input  logic [BLK_WIDTH/WIDTH-1:0]    req_be,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [BLK_WIDTH-1:0]          resp_rdata,
  output logic                          resp_err
);

  localparam int unsigned BLK_BYTES = BLK_WIDTH / WIDTH;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned EW        = PA_WIDTH + 1;
  localparam int unsigned CNT_W     = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Storage starts zeroed (INIT=1) or unknown (INIT=0); reset never touches it.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: ((INIT != 0) ? WIDTH'(0) : {WIDTH{1'bx}})};

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [PA_WIDTH-1:0]  base_q, base_d;
  logic [BLK_WIDTH-1:0] wdata_q, wdata_d;
  logic [BLK_BYTES-1:0] be_q, be_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [BLK_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  logic                 in_range_c;
  logic                 commit_c;
  logic [AW-1:0]        idx_c;
  logic [BLK_WIDTH-1:0] rd_blk_c;

  assign in_range_c = (EW'(base_q) + EW'(BLK_BYTES)) <= EW'(DEPTH);
  assign commit_c   = (state_q == S_WAIT) && (cnt_q == CNT_W'(0));
  assign idx_c      = AW'(base_q);

  // Gather the addressed block, byte i into bits [i*WIDTH +: WIDTH].
  always_comb begin
    rd_blk_c = '0;
    for (int i = 0; i < BLK_BYTES; i++) begin
      rd_blk_c[i*WIDTH +: WIDTH] = mem_q[idx_c + AW'(i)];
    end
  end

  // Masked write on the commit edge; a reset on that edge drops the whole write.
  always_ff @(posedge clk) begin
    if (commit_c && we_q && in_range_c && !rst) begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        if (be_q[i]) begin
          mem_q[idx_c + AW'(i)] <= wdata_q[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          we_d        = req_we;
          base_d      = req_addr & ~(PA_WIDTH'(BLK_BYTES - 1));
          wdata_d     = req_wdata;
          be_d        = req_be;
          cnt_d       = CNT_W'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          resp_valid_d = 1'b1;
          resp_err_d   = !in_range_c;
          resp_rdata_d = (in_range_c && !we_q) ? rd_blk_c : '0;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        // A request offered alongside resp_ready waits for the next IDLE edge.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed-vector bench for main_mem_ctrl: a LATENCY=4 instance for the table and corner
// cases, and a LATENCY=1 instance swept against a byte-array reference model.
module tb_main_mem_ctrl;

  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BLK_WIDTH = 64;
  localparam int unsigned PA_WIDTH  = 16;
  localparam int unsigned BLK_BYTES = 8;
  localparam int unsigned NVEC      = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 req_valid  [2];
  logic                 req_ready  [2];
  logic                 req_we     [2];
  logic [PA_WIDTH-1:0]  req_addr   [2];
  logic [BLK_WIDTH-1:0] req_wdata  [2];
  logic [BLK_BYTES-1:0] req_be     [2];
  logic                 resp_valid [2];
  logic                 resp_ready [2];
  logic [BLK_WIDTH-1:0] resp_rdata [2];
  logic                 resp_err   [2];

  main_mem_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BLK_WIDTH(BLK_WIDTH), .PA_WIDTH(PA_WIDTH),
                  .LATENCY(4), .INIT(1)) u_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  main_mem_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BLK_WIDTH(BLK_WIDTH), .PA_WIDTH(PA_WIDTH),
                  .LATENCY(1), .INIT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  typedef struct {
    logic                 we;
    logic [PA_WIDTH-1:0]  addr;
    logic [BLK_WIDTH-1:0] wdata;
    logic [BLK_BYTES-1:0] be;
    logic [BLK_WIDTH-1:0] exp_rd;
    logic                 exp_err;
  } vec_t;

  vec_t vt [NVEC];
  logic [7:0] ref_mem [DEPTH];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; called #1 after a rising edge, returns #1 after the handshake edge.
  task automatic txn(input int d, input logic we, input logic [PA_WIDTH-1:0] addr,
                     input logic [BLK_WIDTH-1:0] wd, input logic [BLK_BYTES-1:0] be,
                     output logic [BLK_WIDTH-1:0] rd, output logic err, output int lat);
    int guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd; req_be[d] = be;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    rd  = resp_rdata[d];
    err = resp_err[d];
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [BLK_WIDTH-1:0] rd, exp;
    logic err;
    int lat;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_addr[d] = '0; req_wdata[d] = '0;
      req_be[d] = '0; resp_ready[d] = 0;
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    vt[0]  = '{1'b0, 16'h0040, 64'h0, 8'h00, 64'h0, 1'b0};
    vt[1]  = '{1'b1, 16'h0020, 64'h1817161514131211, 8'hFF, 64'h0, 1'b0};
    vt[2]  = '{1'b0, 16'h0027, 64'h0, 8'h00, 64'h1817161514131211, 1'b0};
    vt[3]  = '{1'b1, 16'h0000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b0};
    vt[4]  = '{1'b1, 16'h0000, 64'h0, 8'h55, 64'h0, 1'b0};
    vt[5]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'hFF00FF00FF00FF00, 1'b0};
    vt[6]  = '{1'b1, 16'h03F8, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    vt[7]  = '{1'b0, 16'h03F8, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vt[8]  = '{1'b0, 16'h0400, 64'h0, 8'h00, 64'h0, 1'b1};
    vt[9]  = '{1'b1, 16'h0400, 64'h7777777777777777, 8'hFF, 64'h0, 1'b1};
    vt[10] = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'hFF00FF00FF00FF00, 1'b0};
    vt[11] = '{1'b1, 16'h0020, 64'hAAAAAAAAAAAAAAAA, 8'h80, 64'h0, 1'b0};
    vt[12] = '{1'b0, 16'h0021, 64'h0, 8'h00, 64'hAA17161514131211, 1'b0};
    vt[13] = '{1'b0, 16'h03FF, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vt[14] = '{1'b0, 16'hFFF8, 64'h0, 8'h00, 64'h0, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 64'(req_ready[d]), 64'd1);
      check("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
      check("rst_resp_rdata", resp_rdata[d], 64'd0);
      check("rst_resp_err", 64'(resp_err[d]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a write's wait: the write must vanish.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0040;
    req_wdata[0] = 64'hA5A5A5A5A5A5A5A5; req_be[0] = 8'hFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("midrst_req_ready", 64'(req_ready[0]), 64'd1);
    check("midrst_resp_valid", 64'(resp_valid[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      txn(0, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].be, rd, err, lat);
      check($sformatf("vec%0d_rdata", v), rd, vt[v].exp_rd);
      check($sformatf("vec%0d_err", v), 64'(err), 64'(vt[v].exp_err));
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'd4);
    end

    // Backpressure: response held for 10 cycles while a new request waits.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0020; req_be[0] = 8'h00;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    lat = 0;
    while (!resp_valid[0] && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_latency", 64'(lat), 64'd4);
    req_valid[0] = 1'b1; req_addr[0] = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_resp_valid", c), 64'(resp_valid[0]), 64'd1);
      check($sformatf("bp%0d_rdata", c), resp_rdata[0], 64'hAA17161514131211);
      check($sformatf("bp%0d_req_ready", c), 64'(req_ready[0]), 64'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    check("bp_hs_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("bp_hs_req_ready", 64'(req_ready[0]), 64'd1);
    check("bp_hs_rdata_clr", resp_rdata[0], 64'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("bp_accept_req_ready", 64'(req_ready[0]), 64'd0);
    lat = 0;
    while (!resp_valid[0] && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    check("bp2_latency", 64'(lat), 64'd4);
    check("bp2_rdata", resp_rdata[0], 64'hFF00FF00FF00FF00);
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;

    // LATENCY=1 random masked traffic against the reference byte array.
    for (int k = 0; k < 300; k++) begin
      logic                 we;
      logic [PA_WIDTH-1:0]  addr;
      logic [BLK_WIDTH-1:0] wd;
      logic [BLK_BYTES-1:0] be;
      int                   base;
      base = 8 * int'($urandom_range(0, 127));
      addr = PA_WIDTH'(base + int'($urandom_range(0, 7)));
      we   = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      be   = 8'($urandom_range(0, 255));
      exp  = '0;
      if (we) begin
        for (int i = 0; i < 8; i++) if (be[i]) ref_mem[base + i] = wd[i*8 +: 8];
      end else begin
        for (int i = 0; i < 8; i++) exp[i*8 +: 8] = ref_mem[base + i];
      end
      txn(1, we, addr, wd, be, rd, err, lat);
      check($sformatf("sweep%0d_rdata", k), rd, exp);
      check($sformatf("sweep%0d_err", k), 64'(err), 64'd0);
      check($sformatf("sweep%0d_latency", k), 64'(lat), 64'd1);
    end
    for (int b = 0; b < 128; b++) begin
      for (int i = 0; i < 8; i++) exp[i*8 +: 8] = ref_mem[b*8 + i];
      txn(1, 1'b0, PA_WIDTH'(b * 8), 64'h0, 8'h00, rd, err, lat);
      check($sformatf("final_blk%0d_rdata", b), rd, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
